// File: rtl/dcp_pkg.sv
// Shared definitions for the debug control processor console path:
// ASCII codes, token types, scanner state encoding and a result record.
package dcp_pkg;

    // ASCII codes the scanner treats specially
    localparam logic [7:0] SP = 8'h20;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    // Token type requested by the command FSMs
    localparam logic TOK_CHAR = 1'b0;
    localparam logic TOK_HEX  = 1'b1;

    // Scanner state encoding (kept as plain constants for legacy users)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RX   = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;
    localparam logic [1:0] ST_REL  = 2'd3;

    // Result handed back to the requester together with ack
    typedef struct packed {
        logic [31:0] din;
        logic        flag;
        logic        eol;
    } tok_res_t;

    // True for either line-end character
    function automatic logic is_eol(input logic [7:0] b);
        return (b == CR) || (b == LF);
    endfunction

    // Build a result record
    function automatic tok_res_t make_res(input logic [31:0] din,
                                          input logic        flag,
                                          input logic        eol);
        tok_res_t r;
        r.din  = din;
        r.flag = flag;
        r.eol  = eol;
        return r;
    endfunction

endpackage

// File: rtl/dcp_hex_nib.sv
// ASCII to hex nibble decoder: accepts 0-9, A-F and a-f.
module dcp_hex_nib (
    input  logic [7:0] ascii,
    output logic [3:0] nib,
    output logic       is_hex
);

    // Classify the character and extract its nibble value
    always_comb begin
        nib    = 4'h0;
        is_hex = 1'b0;
        if ((ascii >= 8'h30) && (ascii <= 8'h39)) begin
            nib    = ascii[3:0];
            is_hex = 1'b1;
        end else if ((ascii >= 8'h41) && (ascii <= 8'h46)) begin
            nib    = ascii[3:0] + 4'd9;
            is_hex = 1'b1;
        end else if ((ascii >= 8'h61) && (ascii <= 8'h66)) begin
            nib    = ascii[3:0] + 4'd9;
            is_hex = 1'b1;
        end else begin
            nib    = 4'h0;
            is_hex = 1'b0;
        end
    end

endmodule

// File: rtl/dcp_scan_tok.sv
// Receive-side tokenizer for the DCP console. On request it consumes bytes
// from the UART receiver and returns either one command character or one
// 32-bit hex argument, with an error/line-end flag and an end-of-line bit.
// Optional build macro DCP_SCAN_TIMEOUT_EN: an idle-byte timeout in RX that
// terminates the token as an empty line (din=0, flag=1, eol=1).
module dcp_scan_tok
    import dcp_pkg::*;
#(
    parameter int          MAX_DIGITS     = 8,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  d_rx,
    input  logic        vld_rx,
    output logic        rdy_rx,
    input  logic        type_rx,
    input  logic        req_rx,
    output logic        ack_rx,
    output logic        flag_rx,
    output logic        eol_rx,
    output logic [31:0] din_rx
);

    localparam int             CW      = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_DIGITS);
    localparam logic [CW-1:0]  ONE_CNT = {{(CW-1){1'b0}}, 1'b1};

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic          type_r;
    logic          type_nxt_s;
    logic [31:0]   acc_r;
    logic [31:0]   acc_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          err_r;
    logic          err_nxt_s;
    tok_res_t      res_r;
    tok_res_t      res_nxt_s;
    logic          ack_r;
    logic          rdy_r;
    logic          accept_s;
    logic [3:0]    nib_s;
    logic          is_hex_s;
    logic          to_hit_s;

    dcp_hex_nib u_hex_nib (
        .ascii  (d_rx),
        .nib    (nib_s),
        .is_hex (is_hex_s)
    );

    // rdy is registered, so a byte is only taken while the FSM sits in RX
    assign accept_s = vld_rx & rdy_r;

`ifdef DCP_SCAN_TIMEOUT_EN
    logic [31:0] to_cnt_r;

    assign to_hit_s = (to_cnt_r == (TIMEOUT_CYCLES - 32'd1));

    // Idle-byte counter: runs only in RX, restarts on every byte, saturates
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_cnt_r <= 32'd0;
        end else if ((state_r != ST_RX) || accept_s) begin
            to_cnt_r <= 32'd0;
        end else if (to_cnt_r != 32'hFFFF_FFFF) begin
            to_cnt_r <= to_cnt_r + 32'd1;
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end
`else
    logic unused_timeout_s;

    assign to_hit_s         = 1'b0;
    assign unused_timeout_s = ^TIMEOUT_CYCLES;
`endif

    // Next-state and datapath decisions for the token scanner
    always_comb begin
        state_nxt_s = state_r;
        type_nxt_s  = type_r;
        acc_nxt_s   = acc_r;
        cnt_nxt_s   = cnt_r;
        err_nxt_s   = err_r;
        res_nxt_s   = res_r;

        case (state_r)
            ST_IDLE: begin
                if (req_rx) begin
                    state_nxt_s = ST_RX;
                    type_nxt_s  = type_rx;
                    acc_nxt_s   = 32'h0;
                    cnt_nxt_s   = '0;
                    err_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_RX: begin
                if (!req_rx) begin
                    // Requester gave up: drop whatever was accumulated
                    state_nxt_s = ST_IDLE;
                    acc_nxt_s   = 32'h0;
                    cnt_nxt_s   = '0;
                    err_nxt_s   = 1'b0;
                end else if (accept_s) begin
                    if (type_r == TOK_CHAR) begin
                        if (d_rx == SP) begin
                            state_nxt_s = ST_RX;
                        end else if (is_eol(d_rx)) begin
                            res_nxt_s   = make_res({24'h0, d_rx}, 1'b1, 1'b1);
                            state_nxt_s = ST_ACK;
                        end else begin
                            res_nxt_s   = make_res({24'h0, d_rx}, 1'b0, 1'b0);
                            state_nxt_s = ST_ACK;
                        end
                    end else begin
                        if (is_hex_s) begin
                            if (cnt_r == MAX_CNT) begin
                                // Too many digits: keep the first MAX_DIGITS
                                err_nxt_s = 1'b1;
                            end else begin
                                acc_nxt_s = {acc_r[27:0], nib_s};
                                cnt_nxt_s = cnt_r + ONE_CNT;
                            end
                        end else if (is_eol(d_rx)) begin
                            if (cnt_r == '0) begin
                                res_nxt_s = make_res(32'h0, 1'b1, 1'b1);
                            end else begin
                                res_nxt_s = make_res(acc_r, err_r, 1'b1);
                            end
                            state_nxt_s = ST_ACK;
                        end else if (d_rx == SP) begin
                            if (cnt_r != '0) begin
                                res_nxt_s   = make_res(acc_r, err_r, 1'b0);
                                state_nxt_s = ST_ACK;
                            end else begin
                                // Leading blanks before the first digit
                                state_nxt_s = ST_RX;
                            end
                        end else begin
                            // Junk inside the word: remember it, keep scanning
                            err_nxt_s = 1'b1;
                        end
                    end
                end else if (to_hit_s) begin
                    res_nxt_s   = make_res(32'h0, 1'b1, 1'b1);
                    state_nxt_s = ST_ACK;
                end else begin
                    state_nxt_s = ST_RX;
                end
            end

            ST_ACK: begin
                state_nxt_s = ST_REL;
            end

            ST_REL: begin
                // Wait for the requester to release so one req = one token
                if (!req_rx) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REL;
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
                acc_nxt_s   = 32'h0;
                cnt_nxt_s   = '0;
                err_nxt_s   = 1'b0;
            end
        endcase
    end

    // State, accumulator and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            type_r  <= TOK_CHAR;
            acc_r   <= 32'h0;
            cnt_r   <= '0;
            err_r   <= 1'b0;
            res_r   <= make_res(32'h0, 1'b0, 1'b0);
            ack_r   <= 1'b0;
            rdy_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            type_r  <= type_nxt_s;
            acc_r   <= acc_nxt_s;
            cnt_r   <= cnt_nxt_s;
            err_r   <= err_nxt_s;
            res_r   <= res_nxt_s;
            ack_r   <= (state_nxt_s == ST_ACK);
            rdy_r   <= (state_nxt_s == ST_RX);
        end
    end

    assign rdy_rx  = rdy_r;
    assign ack_rx  = ack_r;
    assign din_rx  = res_r.din;
    assign flag_rx = res_r.flag;
    assign eol_rx  = res_r.eol;

endmodule
